// File: rtl/corr_acc_512.sv
// Lag-domain multiply-accumulate stage: integrates dref*dlag per lag over n_int
// sample bursts into an accumulator RAM, then streams the 512 sums out.
module corr_acc_512 #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       n_int,
  input  logic              sin,
  input  logic [7:0]        dref,
  input  logic [7:0]        dlag,
  input  logic              dlag_valid,
  output logic              busy,
  output logic [ACC_W-1:0]  res_data,
  output logic [ADDR_W-1:0] res_lag,
  output logic              res_valid,
  output logic              done,
  output logic              sat,
  output logic              drop_err
);

  localparam int LAGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAG_MAX = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DUMP  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] lag_cnt;
  logic              armed;
  logic [15:0]       burst_cnt;
  logic [15:0]       n_lat;
  logic              first;
  logic              run_seen;
  logic              drain_cnt;
  logic [ADDR_W-1:0] dump_addr;

  logic [ACC_W-1:0]  mem [LAGS];
  logic [ACC_W-1:0]  ram_q;

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_lag;
  logic [15:0]       s1_p;
  logic              s1_first;

  logic              acc_beat;
  logic              lag_zero;
  logic              last_beat;
  logic              dump_rd;
  logic              drop_hit;
  logic [ADDR_W-1:0] rd_addr;
  logic [ACC_W-1:0]  base;
  logic [ACC_W:0]    sum_wide;
  logic              sat_hit;
  logic [ACC_W-1:0]  wdata;

  assign acc_beat  = (state == ACC) && dlag_valid && armed;
  assign lag_zero  = (lag_cnt == '0);
  assign last_beat = acc_beat && lag_zero && (burst_cnt == (n_lat - 16'd1));
  // The lag-0 dump read is issued in the last drain cycle so the first result
  // appears three cycles after the final beat.
  assign dump_rd   = ((state == DRAIN) && drain_cnt) || ((state == DUMP) && (dump_addr != '0));
  assign rd_addr   = (state == ACC) ? lag_cnt : dump_addr;
  assign drop_hit  = (state != ACC) && (sin || (dlag_valid && ((state != IDLE) || run_seen)));

  assign base     = s1_first ? '0 : ram_q;
  assign sum_wide = {1'b0, base} + (ACC_W+1)'(s1_p);
  assign sat_hit  = sum_wide[ACC_W];
  assign wdata    = sat_hit ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

  assign res_data = ram_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)        next_state = ACC;   else next_state = IDLE;
      ACC:     if (last_beat)    next_state = DRAIN; else next_state = ACC;
      DRAIN:   if (drain_cnt)    next_state = DUMP;  else next_state = DRAIN;
      DUMP:    if (dump_addr == '0) next_state = IDLE; else next_state = DUMP;
      default: next_state = IDLE;
    endcase
  end

  // Lag counter: re-armed by sin during ACC, exhausted after the lag-0 beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lag_cnt <= LAG_MAX;
      armed   <= 1'b0;
    end else if (sin) begin
      lag_cnt <= LAG_MAX;
      armed   <= (state == ACC);
    end else if (acc_beat) begin
      if (lag_zero) armed <= 1'b0;
      else          lag_cnt <= lag_cnt - ADDR_W'(1);
    end else if (state != ACC) begin
      armed <= 1'b0;
    end
  end

  // Run control, burst counting and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat     <= 16'd1;
      burst_cnt <= 16'd0;
      first     <= 1'b1;
      run_seen  <= 1'b0;
      sat       <= 1'b0;
      drop_err  <= 1'b0;
      drain_cnt <= 1'b0;
      dump_addr <= '0;
    end else begin
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      dump_addr <= dump_rd ? dump_addr + ADDR_W'(1) : '0;
      if ((state == IDLE) && start) begin
        n_lat     <= (n_int == 16'd0) ? 16'd1 : n_int;
        burst_cnt <= 16'd0;
        first     <= 1'b1;
        run_seen  <= 1'b1;
        sat       <= 1'b0;
        drop_err  <= 1'b0;
      end else begin
        if (s1_valid && sat_hit) sat <= 1'b1;
        if (drop_hit)            drop_err <= 1'b1;
        if (acc_beat && lag_zero) begin
          burst_cnt <= burst_cnt + 16'd1;
          first     <= 1'b0;
        end
      end
    end
  end

  // Beat pipeline stage 1: product and lag, alongside the RAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lag   <= '0;
      s1_p     <= 16'd0;
      s1_first <= 1'b1;
    end else begin
      s1_valid <= acc_beat;
      s1_lag   <= lag_cnt;
      s1_p     <= 16'(dref) * 16'(dlag);
      s1_first <= first;
    end
  end

  // Accumulator RAM write port (contents intentionally not reset)
  always_ff @(posedge clk) begin
    if (s1_valid) mem[s1_lag] <= wdata;
  end

  // RAM read port, shared between accumulate and dump
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ram_q <= '0;
    else        ram_q <= mem[rd_addr];
  end

  // Registered status and result qualifiers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_lag   <= '0;
    end else begin
      busy      <= (next_state != IDLE);
      done      <= (state == DUMP) && (next_state == IDLE);
      res_valid <= dump_rd;
      if (dump_rd) res_lag <= rd_addr;
    end
  end

endmodule
